imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Program loader for the RISC-V pipeline. Takes a little-endian byte stream
//  over a valid/ready handshake, assembles 32-bit instruction words and writes
//  them into Instruction_Memory through its write port, at a fixed word offset.
//  It zero-clears memory first and asserts start_o once the program is resident.
//  It is the hardware writer side of instruction memory, which the CPU fetch reads.
// PARAMETERS
//  ADDR_W  8  word-address width; memory depth is 2**ADDR_W words
//  BASE    2  word address of the first loaded instruction (offset of PC reset)
// PORTS
//  clk_i         in   1       clock
//  rst_i         in   1       asynchronous reset, active-high
//  byte_valid_i  in   1       byte_data_i holds a valid byte
//  byte_data_i   in   8       program byte, little-endian within each word
//  byte_ready_o  out  1       loader accepts a byte this cycle
//  mem_we_o      out  1       instruction-memory write enable (registered)
//  mem_addr_o    out  ADDR_W  write word address (registered)
//  mem_data_o    out  32      write data (registered)
//  start_o       out  1       program loaded; CPU start_i (sticky until reset)
//  busy_o        out  1       high in CLEAR, LOAD and WRITE
//  overflow_o    out  1       memory filled before a terminating zero word
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_cnt=0, word_idx=0, byte_cnt=0, shift reg=0.
//   Outputs: byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0,
//   start_o=0, busy_o=1, overflow_o=0. Any partial word is discarded.
//  CLEAR: on each edge register mem_we_o=1, mem_addr_o=clr_cnt, mem_data_o=0,
//   and increment clr_cnt. After the write of address 2**ADDR_W-1 is
//   registered, go to LOAD. The write pulses occupy exactly 2**ADDR_W
//   consecutive cycles after reset release. byte_ready_o=0.
//  LOAD: byte_ready_o=1 (combinational from state); mem_we_o=0. A byte is
//   accepted only when byte_valid_i & byte_ready_o. The k-th accepted byte
//   (k=0..3) goes to word bits [8k+7:8k]. Cycles with valid low are ignored.
//   The 4th accepted byte moves the state to WRITE on the same edge.
//  WRITE (1 cycle): byte_ready_o=0. Registers mem_we_o=1,
//   mem_addr_o=(BASE+word_idx) mod 2**ADDR_W, and mem_data_o=word.
//    - word==0: the zero is written (end marker), then the state goes to DONE.
//    - else if word_idx==2**ADDR_W-1: the state goes to DONE and overflow_o=1.
//    - else word_idx++, byte_cnt=0, and the state returns to LOAD.
//  DONE: mem_we_o=0, byte_ready_o=0, busy_o=0. start_o=1 from the edge that
//   leaves WRITE. The state stays in DONE until reset; later bytes are not accepted.
//  Address wrap: with BASE>0 the last BASE words land at 0..BASE-1, modulo depth.
//  Throughput: at least 5 cycles per word (4 accept cycles + 1 write cycle).
//  mem_we_o is never high in two states at once; there is one write per cycle.
//  Reset mid-operation restarts at CLEAR, including the full zero sweep.
// TESTING
//  T1 reset release, no bytes -> 256 cycles of mem_we_o=1, addr 0..255,
//     data 0; then byte_ready_o=1, start_o=0, busy_o=1.
//  T2 bytes 13 05 10 00 then 00 00 00 00 -> write 0x00100513@2, then 0@3;
//     start_o=1 and busy_o=0 after that write; byte_ready_o stays 0.
//  T3 T2 stream with byte_valid_i low on alternate cycles, and valid held
//     during CLEAR/WRITE -> identical writes; no byte consumed while ready=0.
//  T4 256 nonzero words 0x00000001..0x00000100 -> addresses 2..255 then 0,1;
//     overflow_o=1 and start_o=1 after the 256th write.
//  T5 reset pulse after 2 bytes of word 0 -> all outputs return to reset
//     values; CLEAR sweep repeats; next full word is written at address 2.
//  T6 reset pulse in DONE -> start_o drops asynchronously; reload succeeds.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: zero-clears instruction memory, then assembles a
// little-endian byte stream into words written from BASE, then raises start.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BASE   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       shift_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              start_q;
  logic              ovf_q;

  logic              accept;
  logic [4:0]        lane_lsb;
  logic [ADDR_W-1:0] wr_addr_d;

  assign byte_ready_o = (state_q == S_LOAD);
  assign accept       = byte_valid_i & byte_ready_o;
  assign lane_lsb     = {byte_cnt_q, 3'b000};
  // Adder truncates to ADDR_W, so trailing words wrap to low addresses.
  assign wr_addr_d    = BASE_A + word_idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          we_q      <= 1'b1;
          addr_q    <= clr_cnt_q;
          data_q    <= '0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            shift_q[lane_lsb +: 8] <= byte_data_i;
            byte_cnt_q             <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_q   <= 1'b1;
          addr_q <= wr_addr_d;
          data_q <= shift_q;
          if (shift_q == 32'd0) begin
            state_q <= S_DONE;
            start_q <= 1'b1;
          end else if (word_idx_q == LAST) begin
            state_q <= S_DONE;
            start_q <= 1'b1;
            ovf_q   <= 1'b1;
          end else begin
            word_idx_q <= word_idx_q + 1'b1;
            byte_cnt_q <= '0;
            state_q    <= S_LOAD;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign start_o    = start_q;
  assign busy_o     = (state_q != S_DONE);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear sweep, word loads,
// address wrap/overflow and reset in mid-load and in DONE.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              start_o;
  logic              busy_o;
  logic              overflow_o;

  int checks = 0;
  int errors = 0;
  int acc    = 0;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .BASE   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) acc <= 0;
    else if (byte_valid_i && byte_ready_o) acc <= acc + 1;
  end

  typedef struct {
    logic        do_rst;
    logic [31:0] word;
    int          gap;
    logic [7:0]  addr;
    logic        start;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    byte_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_outs",
        {57'd0, byte_ready_o, mem_we_o, start_o, busy_o, overflow_o,
         |mem_addr_o, |mem_data_o},
        {57'd0, 7'b0001000});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_clear();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(mem_we_o === 1'b1 && mem_addr_o === 8'(i) &&
            mem_data_o === 32'd0 && byte_ready_o === (i == 255) &&
            start_o === 1'b0 && busy_o === 1'b1))
        bad++;
    end
    byte_valid_i = 1'b0;
    chk("clear_sweep", 64'(bad), 64'd0);
    @(negedge clk);
    chk("post_clear", {60'd0, byte_ready_o, mem_we_o, start_o, busy_o},
        {60'd0, 4'b1001});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 0;
    if (gap > 0) begin
      byte_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (byte_ready_o) ok = 1;
      @(negedge clk);
    end
    if (!ok) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_write(input string name, input logic [7:0] addr,
                            input logic [31:0] data);
    bit ok;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (mem_we_o) ok = 1;
    end
    if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
    else chk(name, {24'd0, mem_addr_o, mem_data_o}, {24'd0, addr, data});
  endtask

  initial begin
    rst = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    tv[0] = '{1'b0, 32'h0010_0513, 0, 8'd2, 1'b0};
    tv[1] = '{1'b0, 32'h0000_0000, 0, 8'd3, 1'b1};
    tv[2] = '{1'b1, 32'h0010_0513, 1, 8'd2, 1'b0};
    tv[3] = '{1'b0, 32'h0000_0000, 1, 8'd3, 1'b1};

    // T1
    do_reset();
    wait_clear();

    // T2 / T3
    for (int i = 0; i < 4; i++) begin
      if (tv[i].do_rst) begin
        do_reset();
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hFF;
        wait_clear();
        chk("no_acc_clear", 64'(acc), 64'd0);
      end
      send_word(tv[i].word, tv[i].gap);
      wait_write($sformatf("vec%0d_wr", i), tv[i].addr, tv[i].word);
      chk($sformatf("vec%0d_flags", i),
          {60'd0, start_o, busy_o, byte_ready_o, overflow_o},
          {60'd0, tv[i].start, !tv[i].start, !tv[i].start, 1'b0});
    end
    byte_data_i = 8'h55;
    repeat (5) begin
      @(negedge clk);
      chk("done_ready", {62'd0, byte_ready_o, mem_we_o}, 64'd0);
    end
    chk("acc_count", 64'(acc), 64'd8);

    // T4
    do_reset();
    wait_clear();
    for (int i = 0; i < 256; i++) begin
      send_word(32'(i + 1), 0);
      wait_write("ovf_wr", 8'(i + 2), 32'(i + 1));
      if (i >= 254)
        chk($sformatf("ovf_flags%0d", i), {62'd0, overflow_o, start_o},
            {62'd0, i == 255, i == 255});
    end
    byte_valid_i = 1'b0;

    // T5
    do_reset();
    wait_clear();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("mid_acc", 64'(acc), 64'd2);
    do_reset();
    wait_clear();
    send_word(32'hDEAD_BEEF, 0);
    wait_write("t5_wr", 8'd2, 32'hDEAD_BEEF);
    send_word(32'h0, 0);
    wait_write("t5_end", 8'd3, 32'h0);
    chk("t5_start", {63'd0, start_o}, 64'd1);

    // T6
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_start", {62'd0, start_o, busy_o}, {62'd0, 2'b01});
    do_reset();
    wait_clear();
    send_word(32'h0010_0513, 0);
    wait_write("t6_wr", 8'd2, 32'h0010_0513);
    send_word(32'h0, 0);
    wait_write("t6_end", 8'd3, 32'h0);
    chk("t6_start", {62'd0, start_o, busy_o}, {62'd0, 2'b10});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
